aes_block_splitter: RTL and testbench
=====================================

Name: aes_block_splitter

Overview:
- Sits directly downstream of the fetch stage.
- Accepts one 4096-bit text line per handshake and slices it into 128-bit AES plaintext blocks, delivered one per cycle to the cipher core under valid/ready flow control.
- Fetch lines are zero-padded at the MSB end, so all-zero leading blocks are dropped and only meaningful blocks are emitted.

Parameters:
- IN_W, 4096, width of one fetched line in bits.
- BLK_W, 128, width of one emitted AES block in bits. IN_W must be an integer multiple of BLK_W.
- SKIP_LEAD_ZERO, 1, when 1 drop leading all-zero blocks; when 0 emit every block of the line.
- NUM_BLK is derived as IN_W/BLK_W (32 by default). It is a localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- in_data  input  IN_W  line from fetch.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  splitter accepts in_data this cycle.
- out_data  output  BLK_W  current AES block.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream consumes out_data this cycle.
- out_first  output  1  out_data is the first emitted block of its line.
- out_last  output  1  out_data is the final block of its line (block index NUM_BLK-1).
- out_idx  output  5 (clog2 NUM_BLK)  index of out_data within the line. Index 0 is bits [IN_W-1 : IN_W-BLK_W].
- lines_dropped  output  16  count of lines that were entirely zero. Saturates at 16'hFFFF.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values: state=IDLE, out_valid=0, out_first=0, out_last=0, out_idx=0, out_data=0, lines_dropped=0. in_ready evaluates to 1 in IDLE.
- Accept: an input handshake occurs on a rising edge where in_valid && in_ready.
- State machine, IDLE and EMIT:
  - IDLE: in_ready=1.
    - On accept, register in_data into the line buffer.
    - Compute start = index of the lowest-numbered nonzero block, using a priority encoder from index 0. With SKIP_LEAD_ZERO=0, start=0.
    - If the line is all zero and SKIP_LEAD_ZERO=1: stay in IDLE, increment lines_dropped, emit nothing.
    - Otherwise go to EMIT with out_idx=start, out_first=1, out_valid=1, out_last=(start==NUM_BLK-1).
  - EMIT: out_valid=1. out_data equals the buffer block at out_idx, and is stable while out_valid && !out_ready.
    - On out_ready && !out_last: out_idx+1, out_first=0, out_last=(new idx==NUM_BLK-1).
    - On out_ready && out_last: line complete.
- Latency: accept at edge N gives the first out_valid after edge N. Throughput is one block per cycle while out_ready=1.
- in_ready = IDLE || (EMIT && out_valid && out_ready && out_last). This is combinational from out_ready.
- Simultaneous last-block handshake and new accept:
  - Load the new line and stay in EMIT with the new start; there is no bubble.
  - If the new line is all zero (and SKIP_LEAD_ZERO=1), go to IDLE and increment lines_dropped.
- Interior zero blocks (after start) are emitted, not skipped. Only leading zeros are dropped.
- Backpressure: out_valid never deasserts without a handshake. out_data, out_idx, out_first and out_last hold constant while stalled.
- in_data is ignored when in_ready=0. The upstream stage must hold it.
- Reset mid-line: the partial line is discarded. The next cycle has out_valid=0, state=IDLE and lines_dropped=0.
- Counter: lines_dropped does not wrap. It holds at 16'hFFFF.

Test Plan:
1. Reset, then one line with only the low 16 bytes = 0x00112233445566778899AABBCCDDEEFF and out_ready=1: exactly one block, out_idx=31, out_first=1, out_last=1, out_data=0x0011…EEFF; out_valid one cycle after accept.
2. Line with blocks 30 and 31 nonzero and block 29 zero, SKIP_LEAD_ZERO=1: two beats, idx 30 then 31; first/last flags correct. Rerun with SKIP_LEAD_ZERO=0: 32 beats, idx 0..31, blocks 0..29 = 0.
3. Stall: toggle out_ready 1,0,0,1 during a 3-block line: outputs frozen during the zero cycles; exactly 3 handshakes; in_ready=0 until the last handshake.
4. Back-to-back lines A (1 block) and B (2 blocks), in_valid held high: in_ready=1 in the same cycle as A's last handshake; B's first block follows the next cycle with no gap; total 3 beats in 3 cycles.
5. Three all-zero lines then a nonzero line: no out_valid for the zero lines; lines_dropped=3; the nonzero line emits normally.
6. Assert rst for one cycle while emitting block idx 5 of a 10-block line: next cycle out_valid=0, in_ready=1; the following line starts with out_first=1.

Source files
------------

// File: rtl/aes_block_splitter.sv
`default_nettype none
// ============================================================================
// Module   : aes_block_splitter
// Purpose  : Slices one wide fetch line into BLK_W-bit AES plaintext blocks,
//            dropping leading all-zero blocks, with valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module aes_block_splitter #(
  parameter int IN_W           = 4096,
  parameter int BLK_W          = 128,
  parameter int SKIP_LEAD_ZERO = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [IN_W-1:0]                  in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [BLK_W-1:0]                 out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_first,
  output logic                             out_last,
  output logic [$clog2(IN_W/BLK_W)-1:0]    out_idx,
  output logic [15:0]                      lines_dropped
);

  localparam int                NUM_BLK  = IN_W / BLK_W;
  localparam int                IDX_W    = $clog2(NUM_BLK);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_BLK - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t             state_q;
  logic [IN_W-1:0]    line_q;
  logic [BLK_W-1:0]   out_data_q;
  logic               out_valid_q;
  logic               out_first_q;
  logic               out_last_q;
  logic [IDX_W-1:0]   out_idx_q;
  logic [15:0]        dropped_q;

  // Block views of the incoming line and of the buffered line.
  // Block 0 sits at the MSB end of the line.
  logic [BLK_W-1:0]   w_in_blk  [NUM_BLK];
  logic [BLK_W-1:0]   w_buf_blk [NUM_BLK];
  logic [NUM_BLK-1:0] w_in_nz;

  generate
    for (genvar g = 0; g < NUM_BLK; g++) begin : g_blk
      assign w_in_blk[g]  = in_data[IN_W-1-g*BLK_W -: BLK_W];
      assign w_buf_blk[g] = line_q[IN_W-1-g*BLK_W -: BLK_W];
      assign w_in_nz[g]   = |w_in_blk[g];
    end
  endgenerate

  logic [IDX_W-1:0]   w_start;
  logic               w_drop;
  logic               w_accept;
  logic [IDX_W-1:0]   w_idx_nxt;

  // Priority encoder: lowest-numbered nonzero block of the incoming line
  always_comb begin
    w_start = '0;
    for (int i = NUM_BLK - 1; i >= 0; i--) begin
      if (w_in_nz[i]) begin
        w_start = IDX_W'(i);
      end
    end
    if (SKIP_LEAD_ZERO == 0) begin
      w_start = '0;
    end
  end

  // A fully zero line is only discarded when leading-zero skipping is enabled
  assign w_drop    = (SKIP_LEAD_ZERO != 0) && !(|w_in_nz);

  // Ready when idle, or when the final block of the current line is leaving,
  // so the next line can be loaded without a bubble
  assign in_ready  = (state_q == S_IDLE) ||
                     ((state_q == S_EMIT) && out_valid_q && out_ready && out_last_q);
  assign w_accept  = in_valid && in_ready;
  assign w_idx_nxt = out_idx_q + IDX_W'(1);

  // Line buffer, emit state machine and drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_idx_q   <= '0;
      dropped_q   <= '0;
    end else if (w_accept) begin
      line_q <= in_data;
      if (w_drop) begin
        state_q     <= S_IDLE;
        out_valid_q <= 1'b0;
        out_first_q <= 1'b0;
        out_last_q  <= 1'b0;
        if (dropped_q != 16'hFFFF) begin
          dropped_q <= dropped_q + 16'd1;
        end
      end else begin
        state_q     <= S_EMIT;
        out_valid_q <= 1'b1;
        out_first_q <= 1'b1;
        out_idx_q   <= w_start;
        out_last_q  <= (w_start == LAST_IDX);
        out_data_q  <= w_in_blk[w_start];
      end
    end else if ((state_q == S_EMIT) && out_ready) begin
      if (out_last_q) begin
        state_q     <= S_IDLE;
        out_valid_q <= 1'b0;
        out_first_q <= 1'b0;
        out_last_q  <= 1'b0;
      end else begin
        out_idx_q   <= w_idx_nxt;
        out_first_q <= 1'b0;
        out_last_q  <= (w_idx_nxt == LAST_IDX);
        out_data_q  <= w_buf_blk[w_idx_nxt];
      end
    end
  end

  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign out_first     = out_first_q;
  assign out_last      = out_last_q;
  assign out_idx       = out_idx_q;
  assign lines_dropped = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_block_splitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_block_splitter
// Purpose  : Self-checking bench for aes_block_splitter against a
//            line-to-beat-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_block_splitter;

  localparam int IN_W  = 4096;
  localparam int BLK_W = 128;
  localparam int NB    = IN_W / BLK_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  // Instance a: leading-zero skipping on; instance b: skipping off
  logic [IN_W-1:0]  a_in_data = '0, b_in_data = '0;
  logic             a_in_valid = 1'b0, b_in_valid = 1'b0;
  logic             a_out_ready = 1'b0, b_out_ready = 1'b0;
  logic             a_in_ready, b_in_ready;
  logic [BLK_W-1:0] a_out_data, b_out_data;
  logic             a_out_valid, b_out_valid;
  logic             a_out_first, b_out_first;
  logic             a_out_last, b_out_last;
  logic [4:0]       a_out_idx, b_out_idx;
  logic [15:0]      a_lines_dropped, b_lines_dropped;

  aes_block_splitter #(.IN_W(IN_W), .BLK_W(BLK_W), .SKIP_LEAD_ZERO(1)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_first(a_out_first), .out_last(a_out_last),
    .out_idx(a_out_idx), .lines_dropped(a_lines_dropped)
  );

  aes_block_splitter #(.IN_W(IN_W), .BLK_W(BLK_W), .SKIP_LEAD_ZERO(0)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_first(b_out_first), .out_last(b_out_last),
    .out_idx(b_out_idx), .lines_dropped(b_lines_dropped)
  );

  typedef struct {
    logic [BLK_W-1:0] d;
    int               idx;
    bit               first;
    bit               last;
  } beat_t;

  beat_t           exp_q[$];
  logic [IN_W-1:0] send_q[$];
  bit              rdy_pat[$];
  int              dm[2];
  int              checks = 0;
  int              failures = 0;
  int              hs_cnt;
  int              valid_cyc;

  function automatic logic [BLK_W-1:0] blk_of(input logic [IN_W-1:0] l, input int i);
    return l[IN_W-1-i*BLK_W -: BLK_W];
  endfunction

  // Random line whose first nonzero block is 'start' (start==NB: all zero)
  function automatic logic [IN_W-1:0] rand_line(input int start, input int zero_pct);
    logic [IN_W-1:0]  l;
    logic [BLK_W-1:0] b;
    l = '0;
    for (int i = start; i < NB; i++) begin
      b = {$urandom, $urandom, $urandom, $urandom};
      if (i == start) b[0] = 1'b1;
      else if ($urandom_range(0, 99) < zero_pct) b = '0;
      l[IN_W-1-i*BLK_W -: BLK_W] = b;
    end
    return l;
  endfunction

  // Reference: a line becomes the list of blocks from its first meaningful one
  task automatic model_line(input logic [IN_W-1:0] l, input int sel);
    int    s;
    beat_t bt;
    s = -1;
    for (int i = 0; i < NB; i++) if (s < 0 && blk_of(l, i) != '0) s = i;
    if (sel == 0) s = 0;
    if (s < 0) begin
      if (dm[sel] < 65535) dm[sel]++;
      return;
    end
    for (int i = s; i < NB; i++) begin
      bt.d = blk_of(l, i); bt.idx = i; bt.first = (i == s); bt.last = (i == NB - 1);
      exp_q.push_back(bt);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    a_out_ready = 1'b0; b_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete(); send_q.delete(); rdy_pat.delete();
    dm[0] = 0; dm[1] = 0;
  endtask

  // Streams send_q into one instance and checks every cycle against the model.
  // mode 0: out_ready=1, 1: random, 2: from rdy_pat
  task automatic stream(input int sel, input int mode, input int max_cyc);
    int               cyc;
    logic             ov, of, ol, ir, rdy, iv;
    logic [BLK_W-1:0] od;
    logic [4:0]       oi;
    logic [15:0]      ld;
    cyc = 0; hs_cnt = 0; valid_cyc = 0;
    while ((send_q.size() != 0 || exp_q.size() != 0) && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      if (sel == 1) begin
        ov = a_out_valid; od = a_out_data; oi = a_out_idx;
        of = a_out_first; ol = a_out_last; ld = a_lines_dropped;
      end else begin
        ov = b_out_valid; od = b_out_data; oi = b_out_idx;
        of = b_out_first; ol = b_out_last; ld = b_lines_dropped;
      end
      checks++;
      if (ov !== (exp_q.size() != 0)) begin
        failures++; $display("FAIL out_valid sel=%0d: got %b expected %b", sel, ov, exp_q.size() != 0);
      end
      if (ov === 1'b1 && exp_q.size() != 0) begin
        valid_cyc++;
        checks++;
        if (od !== exp_q[0].d) begin
          failures++; $display("FAIL out_data sel=%0d: got %h expected %h", sel, od, exp_q[0].d);
        end
        checks++;
        if (oi !== 5'(exp_q[0].idx)) begin
          failures++; $display("FAIL out_idx sel=%0d: got %0d expected %0d", sel, oi, exp_q[0].idx);
        end
        checks++;
        if (of !== exp_q[0].first) begin
          failures++; $display("FAIL out_first sel=%0d: got %b expected %b", sel, of, exp_q[0].first);
        end
        checks++;
        if (ol !== exp_q[0].last) begin
          failures++; $display("FAIL out_last sel=%0d: got %b expected %b", sel, ol, exp_q[0].last);
        end
      end
      checks++;
      if (ld !== 16'(dm[sel])) begin
        failures++; $display("FAIL lines_dropped sel=%0d: got %0d expected %0d", sel, ld, dm[sel]);
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = (rdy_pat.size() != 0) ? rdy_pat.pop_front() : 1'b1;
      endcase
      iv = (send_q.size() != 0);
      if (sel == 1) begin
        a_out_ready = rdy; a_in_valid = iv;
        if (iv) a_in_data = send_q[0];
      end else begin
        b_out_ready = rdy; b_in_valid = iv;
        if (iv) b_in_data = send_q[0];
      end
      #1;
      ir = (sel == 1) ? a_in_ready : b_in_ready;
      checks++;
      if (ir !== (exp_q.size() == 0 || (rdy && exp_q[0].last))) begin
        failures++; $display("FAIL in_ready sel=%0d: got %b expected %b", sel, ir,
                             exp_q.size() == 0 || (rdy && exp_q[0].last));
      end
      if (ov === 1'b1 && rdy && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        hs_cnt++;
      end
      if (iv && ir === 1'b1) model_line(send_q.pop_front(), sel);
    end
    checks++;
    if (cyc >= max_cyc) begin
      failures++; $display("FAIL stream_timeout sel=%0d: got %0d cycles limit %0d", sel, cyc, max_cyc);
      exp_q.delete(); send_q.delete();
    end
    @(negedge clk);
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    ov = (sel == 1) ? a_out_valid : b_out_valid;
    checks++;
    if (ov !== 1'b0) begin
      failures++; $display("FAIL idle_after_line sel=%0d: got out_valid=%b expected 0", sel, ov);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b expected 0", a_out_valid); end
    checks++; if (a_out_first !== 1'b0) begin failures++; $display("FAIL rst_out_first: got %b expected 0", a_out_first); end
    checks++; if (a_out_last !== 1'b0) begin failures++; $display("FAIL rst_out_last: got %b expected 0", a_out_last); end
    checks++; if (a_out_idx !== 5'd0) begin failures++; $display("FAIL rst_out_idx: got %0d expected 0", a_out_idx); end
    checks++; if (a_out_data !== '0) begin failures++; $display("FAIL rst_out_data: got %h expected 0", a_out_data); end
    checks++; if (a_lines_dropped !== 16'd0) begin failures++; $display("FAIL rst_dropped: got %0d expected 0", a_lines_dropped); end
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b expected 1", a_in_ready); end
    checks++; if (b_out_valid !== 1'b0) begin failures++; $display("FAIL rst_b_out_valid: got %b expected 0", b_out_valid); end
  endtask

  task automatic test_single_block();
    logic [IN_W-1:0] l;
    l = '0;
    l[127:0] = 128'h00112233445566778899AABBCCDDEEFF;
    send_q.push_back(l);
    stream(1, 0, 100);
    checks++; if (hs_cnt !== 1) begin failures++; $display("FAIL single_beats: got %0d expected 1", hs_cnt); end
    checks++; if (valid_cyc !== 1) begin failures++; $display("FAIL single_valid_cycles: got %0d expected 1", valid_cyc); end
  endtask

  task automatic test_two_blocks();
    logic [IN_W-1:0] l;
    l = rand_line(30, 0);
    send_q.push_back(l);
    stream(1, 0, 100);
    checks++; if (hs_cnt !== 2) begin failures++; $display("FAIL two_block_beats: got %0d expected 2", hs_cnt); end
    send_q.push_back(l);
    stream(0, 0, 200);
    checks++; if (hs_cnt !== 32) begin failures++; $display("FAIL noskip_beats: got %0d expected 32", hs_cnt); end
  endtask

  task automatic test_stall();
    send_q.push_back(rand_line(29, 0));
    rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    stream(1, 2, 100);
    checks++; if (hs_cnt !== 3) begin failures++; $display("FAIL stall_beats: got %0d expected 3", hs_cnt); end
    checks++; if (valid_cyc !== 5) begin failures++; $display("FAIL stall_valid_cycles: got %0d expected 5", valid_cyc); end
  endtask

  task automatic test_back_to_back();
    send_q.push_back(rand_line(31, 0));
    send_q.push_back(rand_line(30, 0));
    stream(1, 0, 100);
    checks++; if (hs_cnt !== 3) begin failures++; $display("FAIL b2b_beats: got %0d expected 3", hs_cnt); end
    checks++; if (valid_cyc !== 3) begin failures++; $display("FAIL b2b_valid_cycles: got %0d expected 3", valid_cyc); end
  endtask

  task automatic test_drop_zero();
    logic [IN_W-1:0] z;
    z = '0;
    repeat (3) send_q.push_back(z);
    send_q.push_back(rand_line(28, 30));
    stream(1, 0, 100);
    checks++; if (a_lines_dropped !== 16'd3) begin failures++; $display("FAIL dropped_count: got %0d expected 3", a_lines_dropped); end
    checks++; if (hs_cnt !== 4) begin failures++; $display("FAIL drop_then_line_beats: got %0d expected 4", hs_cnt); end
  endtask

  task automatic test_reset_mid_line();
    bit found;
    found = 1'b0;
    @(negedge clk);
    a_in_data = rand_line(22, 0); a_in_valid = 1'b1; a_out_ready = 1'b1;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      a_in_valid = 1'b0;
      if (a_out_valid === 1'b1 && a_out_idx === 5'd27) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL midline_reach: got no beat at idx 27 expected one"); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid: got %b expected 0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready: got %b expected 1", a_in_ready); end
    checks++; if (a_lines_dropped !== 16'd0) begin failures++; $display("FAIL midrst_dropped: got %0d expected 0", a_lines_dropped); end
    exp_q.delete(); dm[1] = 0;
    send_q.push_back(rand_line(26, 20));
    stream(1, 0, 100);
  endtask

  task automatic test_random();
    int s;
    for (int n = 0; n < 14; n++) begin
      s = ($urandom_range(0, 5) == 0) ? NB : $urandom_range(0, NB - 1);
      send_q.push_back(rand_line(s, 25));
    end
    stream(1, 1, 4000);
    for (int n = 0; n < 3; n++) send_q.push_back(rand_line($urandom_range(0, NB), 25));
    stream(0, 1, 2000);
  endtask

  initial begin
    do_reset();
    test_reset();
    test_single_block();
    test_two_blocks();
    test_stall();
    test_back_to_back();
    do_reset();
    test_drop_zero();
    test_reset_mid_line();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
